mux_select: RTL and testbench

//  Parameterised 2**SELECT_LINES-to-1 single-bit multiplexer with a registered output.
//  Bit data_in[select] is captured on each rising clk edge and driven on data_out.

---
 rtl/mux_select_pkg.sv | 17 +
 rtl/mux_select_mux2_cell.sv | 27 ++
 rtl/mux_select.sv | 73 +++++++
 tb/tb_mux_select.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mux_select_pkg.sv
// -----------------------------------------------------------------------------
// mux_select_pkg
//   Shared constants and helpers for the mux_select bit-pick primitive.
//   ARCH_BEHAVIORAL / ARCH_STRUCTURAL : recognised implementation-style names.
//   n_inputs()                        : data bus width for a given select width.
// -----------------------------------------------------------------------------
package mux_select_pkg;

    localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
    localparam string ARCH_STRUCTURAL = "STRUCTURAL";

    // Number of candidate bits addressed by a select bus of sel_lines bits.
    function automatic int n_inputs(input int sel_lines);
        return 32'sd1 << sel_lines;
    endfunction

endpackage : mux_select_pkg

// File: rtl/mux_select_mux2_cell.sv
// -----------------------------------------------------------------------------
// mux2_cell
//   Purely combinational 2:1 single-bit multiplexer; leaf cell of the
//   structural selection tree.
//   a    in  1  passed when sel = 0 (even-indexed input of a pair)
//   b    in  1  passed when sel = 1 (odd-indexed input of a pair)
//   sel  in  1  steering bit
//   y    out 1  selected bit
// -----------------------------------------------------------------------------
module mux2_cell (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    // Pick b on sel high, a otherwise.
    always_comb begin
        y = 1'b0;
        if (sel) begin
            y = b;
        end else begin
            y = a;
        end
    end

endmodule : mux2_cell

// File: rtl/mux_select.sv
// -----------------------------------------------------------------------------
// mux_select
//   2**SELECT_LINES-to-1 single-bit multiplexer with a registered output.
//   data_in[select] is captured on every rising clk edge (latency 1, no enable).
//   ARCHITECTURE = "STRUCTURAL" builds a log2 tree of mux2_cell instances;
//   any other value uses a plain indexed bit-select. Both are identical at
//   data_out cycle for cycle.
//   clk       in   1                 rising-edge clock
//   rst_n     in   1                 asynchronous active-low reset (clears data_out)
//   select    in   SELECT_LINES      index of the bit to pass
//   data_in   in   2**SELECT_LINES   candidate bits
//   data_out  out  1                 registered selected bit
// -----------------------------------------------------------------------------
module mux_select
    import mux_select_pkg::*;
#(
    parameter string ARCHITECTURE = ARCH_BEHAVIORAL,
    parameter int    SELECT_LINES = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [SELECT_LINES-1:0]              select,
    input  logic [n_inputs(SELECT_LINES)-1:0]    data_in,
    output logic                                 data_out
);

    localparam int N_IN = n_inputs(SELECT_LINES);

    // Combinational pick feeding the D input of the single output flop.
    logic mux_d_s;

    if (ARCHITECTURE == ARCH_STRUCTURAL) begin : g_structural
        // Level l halves the candidate set using select[l]; level 0 pairs
        // data_in[2i] (a) with data_in[2i+1] (b). The root is the last level.
        for (genvar l = 0; l < SELECT_LINES; l++) begin : g_lvl
            localparam int W = N_IN >> (l + 1);
            logic [2*W-1:0] in_s;
            logic [W-1:0]   out_s;

            if (l == 0) begin : g_src
                assign in_s = data_in;
            end else begin : g_src
                assign in_s = g_lvl[l-1].out_s;
            end

            for (genvar i = 0; i < W; i++) begin : g_cell
                mux2_cell u_cell (
                    .a   (in_s[2*i]),
                    .b   (in_s[2*i+1]),
                    .sel (select[l]),
                    .y   (out_s[i])
                );
            end
        end

        assign mux_d_s = g_lvl[SELECT_LINES-1].out_s[0];
    end else begin : g_behavioral
        // Every select value addresses a real bit, so no range guard is needed.
        always_comb begin
            mux_d_s = data_in[select];
        end
    end

    // Output register shared by both architectures; reset clears it without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= 1'b0;
        end else begin
            data_out <= mux_d_s;
        end
    end

endmodule : mux_select

// File: tb/tb_mux_select.sv
// -----------------------------------------------------------------------------
// tb_mux_select
//   Self-checking bench for mux_select. Seven builds share one clock, reset
//   and stimulus bus: BEHAVIORAL and STRUCTURAL at SELECT_LINES 1, 3, 4, plus
//   an unrecognised ARCHITECTURE string at 4. Narrow builds see the low bits
//   of the shared select/data buses. Expected values come from a bit-pick
//   reference computed with shifts and modulo arithmetic.
// -----------------------------------------------------------------------------
module tb_mux_select;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  sel_r  = 4'd0;
    logic [15:0] data_r = 16'd0;

    logic out_b4_s, out_s4_s, out_b3_s, out_s3_s, out_b1_s, out_s1_s, out_x4_s;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mux_select #(.ARCHITECTURE("BEHAVIORAL"), .SELECT_LINES(4)) u_b4 (
        .clk(clk), .rst_n(rst_n), .select(sel_r), .data_in(data_r), .data_out(out_b4_s));
    mux_select #(.ARCHITECTURE("STRUCTURAL"), .SELECT_LINES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .select(sel_r), .data_in(data_r), .data_out(out_s4_s));
    mux_select #(.ARCHITECTURE("BEHAVIORAL"), .SELECT_LINES(3)) u_b3 (
        .clk(clk), .rst_n(rst_n), .select(sel_r[2:0]), .data_in(data_r[7:0]), .data_out(out_b3_s));
    mux_select #(.ARCHITECTURE("STRUCTURAL"), .SELECT_LINES(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .select(sel_r[2:0]), .data_in(data_r[7:0]), .data_out(out_s3_s));
    mux_select #(.ARCHITECTURE("BEHAVIORAL"), .SELECT_LINES(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .select(sel_r[0:0]), .data_in(data_r[1:0]), .data_out(out_b1_s));
    mux_select #(.ARCHITECTURE("STRUCTURAL"), .SELECT_LINES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .select(sel_r[0:0]), .data_in(data_r[1:0]), .data_out(out_s1_s));
    mux_select #(.ARCHITECTURE("OTHER"), .SELECT_LINES(4)) u_x4 (
        .clk(clk), .rst_n(rst_n), .select(sel_r), .data_in(data_r), .data_out(out_x4_s));

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_bit(input string tag, input logic obs, input logic exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: data_out=%b expected=%b (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference: a select of `lines` bits sees only the low lines bits of the
    // shared select bus and only the low 2**lines bits of the data bus.
    function automatic logic ref_bit(input logic [15:0] dat, input logic [3:0] sel, input int lines);
        int n;
        int idx;
        n   = 1 << lines;
        idx = int'(sel) % n;
        return dat[idx];
    endfunction

    // Compare every build against the reference for the values captured last edge.
    task automatic check_all(input string tag, input logic [3:0] sel, input logic [15:0] dat);
        check_bit({tag, "/b4"}, out_b4_s, ref_bit(dat, sel, 4));
        check_bit({tag, "/s4"}, out_s4_s, ref_bit(dat, sel, 4));
        check_bit({tag, "/b3"}, out_b3_s, ref_bit(dat, sel, 3));
        check_bit({tag, "/s3"}, out_s3_s, ref_bit(dat, sel, 3));
        check_bit({tag, "/b1"}, out_b1_s, ref_bit(dat, sel, 1));
        check_bit({tag, "/s1"}, out_s1_s, ref_bit(dat, sel, 1));
        check_bit({tag, "/x4"}, out_x4_s, ref_bit(dat, sel, 4));
    endtask

    // Every build must read the same constant (used around reset).
    task automatic check_const(input string tag, input logic exp_v);
        check_bit({tag, "/b4"}, out_b4_s, exp_v);
        check_bit({tag, "/s4"}, out_s4_s, exp_v);
        check_bit({tag, "/b3"}, out_b3_s, exp_v);
        check_bit({tag, "/s3"}, out_s3_s, exp_v);
        check_bit({tag, "/b1"}, out_b1_s, exp_v);
        check_bit({tag, "/s1"}, out_s1_s, exp_v);
        check_bit({tag, "/x4"}, out_x4_s, exp_v);
    endtask

    // Drive one vector between edges, then check one cycle later.
    task automatic apply(input logic [3:0] sel, input logic [15:0] dat, input string tag);
        @(negedge clk);
        sel_r  = sel;
        data_r = dat;
        @(posedge clk);
        #1;
        check_all(tag, sel, dat);
    endtask

    initial begin : stim
        logic [15:0] sweep_v;
        logic [15:0] wk;

        // Reset: all-ones data, select 0, output must stay 0 through edges.
        sel_r  = 4'd0;
        data_r = 16'hFFFF;
        #2;
        rst_n = 1'b0;
        #1;
        check_const("rst_async", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_const("rst_held", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_const("rst_release_noedge", 1'b0);
        @(posedge clk);
        #1;
        check_const("rst_first_edge", 1'b1);

        // Sweep: 0x02AA with select 0..9 gives alternating 0,1.
        sweep_v = 16'h02AA;
        for (int s = 0; s < 10; s++) begin
            apply(4'(s), sweep_v, $sformatf("sweep_s%0d", s));
            check_bit("sweep_pattern", out_b4_s, 1'(s % 2));
        end

        // Exhaustive walking one: only select == k yields 1.
        for (int s = 0; s < 16; s++) begin
            for (int k = 0; k < 16; k++) begin
                wk = 16'd1 << k;
                apply(4'(s), wk, $sformatf("walk_s%0d_k%0d", s, k));
            end
        end

        // Mid-run reset between edges while the output is 1.
        apply(4'd0, 16'hFFFF, "midrst_pre");
        check_bit("midrst_pre_one", out_s4_s, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_const("midrst_async", 1'b0);
        @(posedge clk);
        #1;
        check_const("midrst_held", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_const("midrst_release_noedge", 1'b0);
        @(posedge clk);
        #1;
        check_const("midrst_recover", 1'b1);

        // Same-edge update: new select and new data are used together.
        apply(4'd3, 16'h0008, "same_a");
        apply(4'd4, 16'h0008, "same_b");
        check_bit("same_new_bit4_zero", out_s4_s, 1'b0);
        apply(4'd3, 16'h0000, "same_c");
        apply(4'd4, 16'h0010, "same_d");
        check_bit("same_new_bit4_one", out_b4_s, 1'b1);

        // Random traffic across all builds.
        for (int r = 0; r < 300; r++) begin
            apply(4'($urandom_range(15, 0)), 16'($urandom), $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_mux_select
